// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversamples the async SPI pins in I_clk, receives MOSI words and
// returns MISO words from a one-entry holding register (IDLE_WORD when nothing is queued).
module spi_slave_responder #(
  parameter int              WIDTH       = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(8'hFF)
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_spi_sck,
  input  logic             I_spi_cs,
  input  logic             I_spi_mosi,
  output logic             O_spi_miso,
  input  logic [WIDTH-1:0] I_tx_data,
  input  logic             I_tx_valid,
  output logic             O_tx_ready,
  output logic [WIDTH-1:0] O_rx_data,
  output logic             O_rx_valid,
  output logic             O_tx_underrun,
  output logic             O_busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic [SYNC_STAGES:0]   flush;
  logic                   armed;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  logic                   hold_full;
  logic [WIDTH-1:0]       hold_data;
  logic [WIDTH-1:0]       shift_tx, shift_rx;
  logic [CW-1:0]          bit_cnt;
  logic                   next_load;

  logic                   tx_accept, start_frame, end_frame, act_rise, act_fall;
  logic                   do_load, do_shift;
  logic [WIDTH-1:0]       load_word, rx_word;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // armed stays low until CS has been seen high with a flushed synchronizer, so a frame
  // already in progress when reset is released is ignored.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      flush     <= '0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], I_spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], I_spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], I_spi_mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
      if (flush[SYNC_STAGES] && cs_s && cs_d)
        armed <= 1'b1;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d & armed;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    O_busy      = (state == ACTIVE);
    O_tx_ready  = ~hold_full;
    tx_accept   = I_tx_valid & ~hold_full;
    start_frame = (state == IDLE) & cs_fall;
    end_frame   = (state == ACTIVE) & cs_rise;
    act_rise    = (state == ACTIVE) & ~cs_rise & sck_rise;
    act_fall    = (state == ACTIVE) & ~cs_rise & sck_fall;
    do_load     = start_frame | (act_fall & next_load);
    do_shift    = act_fall & ~next_load;
    load_word   = hold_full ? hold_data : IDLE_WORD;
    rx_word     = {shift_rx[WIDTH-2:0], mosi_s};
  end

  // An accept can only happen while the holding register is empty, so it never races a
  // LOAD that drains it; a LOAD from empty takes IDLE_WORD and the new word waits.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      hold_full     <= 1'b0;
      hold_data     <= '0;
      shift_tx      <= '0;
      shift_rx      <= '0;
      bit_cnt       <= '0;
      next_load     <= 1'b0;
      O_spi_miso    <= 1'b0;
      O_rx_data     <= '0;
      O_rx_valid    <= 1'b0;
      O_tx_underrun <= 1'b0;
    end else begin
      O_rx_valid    <= 1'b0;
      O_tx_underrun <= 1'b0;

      if (tx_accept) begin
        hold_full <= 1'b1;
        hold_data <= I_tx_data;
      end else if (do_load) begin
        hold_full <= 1'b0;
      end

      if (do_load) begin
        shift_tx      <= load_word;
        O_spi_miso    <= load_word[WIDTH-1];
        O_tx_underrun <= ~hold_full;
      end else if (do_shift) begin
        shift_tx   <= {shift_tx[WIDTH-2:0], 1'b0};
        O_spi_miso <= shift_tx[WIDTH-2];
      end else if (end_frame) begin
        O_spi_miso <= 1'b0;
      end

      if (end_frame) begin
        bit_cnt   <= '0;
        next_load <= 1'b0;
      end else begin
        if (do_load)
          next_load <= 1'b0;
        if (act_rise) begin
          shift_rx <= rx_word;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            bit_cnt    <= '0;
            next_load  <= 1'b1;
            O_rx_data  <= rx_word;
            O_rx_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a behavioural SPI master drives frames and
// each scenario task compares the exchanged words against hand-computed values.
module tb_spi_slave_responder;

  localparam int HALF = 6;

  logic       I_clk = 1'b0;
  logic       I_rst_n;
  logic       spi_sck, spi_cs, spi_mosi;
  logic       O_spi_miso;
  logic [7:0] I_tx_data;
  logic       I_tx_valid;
  logic       O_tx_ready;
  logic [7:0] O_rx_data;
  logic       O_rx_valid;
  logic       O_tx_underrun;
  logic       O_busy;

  int         total = 0;
  int         bad = 0;
  logic [7:0] rx_log[$];
  int         underrun_cnt = 0;
  int         start_underruns = 0;
  logic [15:0] miso_got;

  spi_slave_responder #(.WIDTH(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
    .I_clk         (I_clk),
    .I_rst_n       (I_rst_n),
    .I_spi_sck     (spi_sck),
    .I_spi_cs      (spi_cs),
    .I_spi_mosi    (spi_mosi),
    .O_spi_miso    (O_spi_miso),
    .I_tx_data     (I_tx_data),
    .I_tx_valid    (I_tx_valid),
    .O_tx_ready    (O_tx_ready),
    .O_rx_data     (O_rx_data),
    .O_rx_valid    (O_rx_valid),
    .O_tx_underrun (O_tx_underrun),
    .O_busy        (O_busy)
  );

  always #5 I_clk = ~I_clk;

  // Pulse outputs are logged on the falling edge, away from the register updates.
  always @(negedge I_clk) begin
    if (O_rx_valid) rx_log.push_back(O_rx_data);
    if (O_tx_underrun) underrun_cnt++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge I_clk);
    #2;
  endtask

  task automatic queue_tx(input logic [7:0] d);
    int n = 0;
    while (O_tx_ready !== 1'b1 && n < 300) begin
      wait_clk(1);
      n++;
    end
    total++;
    if (O_tx_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL tx_ready_wait: O_tx_ready=%b expected 1", O_tx_ready);
    end
    I_tx_data  = d;
    I_tx_valid = 1'b1;
    wait_clk(1);
    I_tx_valid = 1'b0;
  endtask

  // Mode-0 master: MOSI changes while SCK is low, MISO is captured at each rising edge.
  task automatic spi_frame(input int nbits, input logic [15:0] mosi_vec,
                           output logic [15:0] miso_vec);
    int u0;
    miso_vec = '0;
    u0 = underrun_cnt;
    spi_cs   = 1'b0;
    spi_mosi = mosi_vec[nbits-1];
    wait_clk(HALF);
    start_underruns = underrun_cnt - u0;
    for (int i = nbits - 1; i >= 0; i--) begin
      miso_vec[i] = O_spi_miso;
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
      if (i > 0) spi_mosi = mosi_vec[i-1];
      wait_clk(HALF);
    end
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(HALF + 4);
  endtask

  task automatic test_reset();
    int n0;
    I_rst_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    I_tx_valid = 1'b0; I_tx_data = 8'h00;
    wait_clk(3);
    total++; if (O_spi_miso !== 1'b0) begin bad++; $display("[TB] FAIL rst_miso: got %b expected 0", O_spi_miso); end
    total++; if (O_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_tx_ready: got %b expected 1", O_tx_ready); end
    total++; if (O_rx_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_rx_data: got %h expected 00", O_rx_data); end
    total++; if (O_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rx_valid: got %b expected 0", O_rx_valid); end
    total++; if (O_tx_underrun !== 1'b0) begin bad++; $display("[TB] FAIL rst_underrun: got %b expected 0", O_tx_underrun); end
    total++; if (O_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", O_busy); end
    I_rst_n = 1'b1;
    wait_clk(6);
    n0 = rx_log.size();
    for (int i = 0; i < 10; i++) begin
      spi_mosi = i[0];
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
      wait_clk(HALF);
    end
    total++; if (O_busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b expected 0", O_busy); end
    total++; if (O_spi_miso !== 1'b0) begin bad++; $display("[TB] FAIL idle_miso: got %b expected 0", O_spi_miso); end
    total++; if (rx_log.size() !== n0) begin bad++; $display("[TB] FAIL idle_rx_pulses: got %0d expected %0d", rx_log.size(), n0); end
    total++; if (O_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_tx_ready: got %b expected 1", O_tx_ready); end
    total++; if (underrun_cnt !== 0) begin bad++; $display("[TB] FAIL idle_underrun: got %0d expected 0", underrun_cnt); end
  endtask

  task automatic test_single_word();
    int n0;
    n0 = rx_log.size();
    queue_tx(8'hA5);
    total++; if (O_tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_ready_drop: got %b expected 0", O_tx_ready); end
    spi_frame(8, 16'h003C, miso_got);
    total++; if (miso_got[7:0] !== 8'hA5) begin bad++; $display("[TB] FAIL single_miso: got %h expected a5", miso_got[7:0]); end
    total++; if (rx_log.size() !== n0 + 1) begin bad++; $display("[TB] FAIL single_rx_pulses: got %0d expected %0d", rx_log.size(), n0 + 1); end
    total++; if (rx_log[n0] !== 8'h3C) begin bad++; $display("[TB] FAIL single_rx_word: got %h expected 3c", rx_log[n0]); end
    total++; if (O_rx_data !== 8'h3C) begin bad++; $display("[TB] FAIL single_rx_data_held: got %h expected 3c", O_rx_data); end
    total++; if (O_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready_back: got %b expected 1", O_tx_ready); end
    total++; if (start_underruns !== 0) begin bad++; $display("[TB] FAIL single_start_underrun: got %0d expected 0", start_underruns); end
    total++; if (O_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_after: got %b expected 0", O_busy); end
    total++; if (O_spi_miso !== 1'b0) begin bad++; $display("[TB] FAIL single_miso_after: got %b expected 0", O_spi_miso); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = rx_log.size();
    queue_tx(8'h12);
    fork
      spi_frame(16, 16'hF00F, miso_got);
      queue_tx(8'h34);
    join
    total++; if (miso_got !== 16'h1234) begin bad++; $display("[TB] FAIL b2b_miso: got %h expected 1234", miso_got); end
    total++; if (rx_log.size() !== n0 + 2) begin bad++; $display("[TB] FAIL b2b_rx_pulses: got %0d expected %0d", rx_log.size(), n0 + 2); end
    total++; if (rx_log[n0] !== 8'hF0) begin bad++; $display("[TB] FAIL b2b_rx_word0: got %h expected f0", rx_log[n0]); end
    total++; if (rx_log[n0+1] !== 8'h0F) begin bad++; $display("[TB] FAIL b2b_rx_word1: got %h expected 0f", rx_log[n0+1]); end
  endtask

  task automatic test_underrun();
    int n0;
    n0 = rx_log.size();
    spi_frame(8, 16'h0055, miso_got);
    total++; if (miso_got[7:0] !== 8'hFF) begin bad++; $display("[TB] FAIL underrun_miso: got %h expected ff", miso_got[7:0]); end
    total++; if (start_underruns !== 1) begin bad++; $display("[TB] FAIL underrun_at_cs_fall: got %0d expected 1", start_underruns); end
    total++; if (rx_log.size() !== n0 + 1) begin bad++; $display("[TB] FAIL underrun_rx_pulses: got %0d expected %0d", rx_log.size(), n0 + 1); end
    total++; if (rx_log[n0] !== 8'h55) begin bad++; $display("[TB] FAIL underrun_rx_word: got %h expected 55", rx_log[n0]); end
  endtask

  task automatic test_abort();
    int n0;
    n0 = rx_log.size();
    queue_tx(8'h81);
    spi_frame(4, 16'h000A, miso_got);
    total++; if (miso_got[3:0] !== 4'h8) begin bad++; $display("[TB] FAIL abort_partial_miso: got %h expected 8", miso_got[3:0]); end
    total++; if (rx_log.size() !== n0) begin bad++; $display("[TB] FAIL abort_no_rx: got %0d expected %0d", rx_log.size(), n0); end
    total++; if (O_spi_miso !== 1'b0) begin bad++; $display("[TB] FAIL abort_miso_low: got %b expected 0", O_spi_miso); end
    total++; if (O_rx_data !== 8'h55) begin bad++; $display("[TB] FAIL abort_rx_data_held: got %h expected 55", O_rx_data); end
    spi_frame(8, 16'h0096, miso_got);
    total++; if (miso_got[7:0] !== 8'hFF) begin bad++; $display("[TB] FAIL abort_next_miso: got %h expected ff", miso_got[7:0]); end
    total++; if (rx_log.size() !== n0 + 1) begin bad++; $display("[TB] FAIL abort_next_pulses: got %0d expected %0d", rx_log.size(), n0 + 1); end
    total++; if (rx_log[n0] !== 8'h96) begin bad++; $display("[TB] FAIL abort_next_rx: got %h expected 96", rx_log[n0]); end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    n0 = rx_log.size();
    spi_cs = 1'b0;
    spi_mosi = 1'b1;
    wait_clk(HALF);
    for (int i = 0; i < 3; i++) begin
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
      wait_clk(HALF);
    end
    total++; if (O_busy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", O_busy); end
    queue_tx(8'h77);
    total++; if (O_tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_held_word: got %b expected 0", O_tx_ready); end
    I_rst_n = 1'b0;
    wait_clk(2);
    total++; if (O_spi_miso !== 1'b0) begin bad++; $display("[TB] FAIL midrst_miso: got %b expected 0", O_spi_miso); end
    total++; if (O_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_tx_ready: got %b expected 1", O_tx_ready); end
    total++; if (O_rx_data !== 8'h00) begin bad++; $display("[TB] FAIL midrst_rx_data: got %h expected 00", O_rx_data); end
    total++; if (O_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", O_busy); end
    I_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
      wait_clk(HALF);
    end
    total++; if (O_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ignored_busy: got %b expected 0", O_busy); end
    total++; if (O_spi_miso !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ignored_miso: got %b expected 0", O_spi_miso); end
    total++; if (rx_log.size() !== n0) begin bad++; $display("[TB] FAIL midrst_ignored_rx: got %0d expected %0d", rx_log.size(), n0); end
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(HALF + 4);
    queue_tx(8'h5A);
    spi_frame(8, 16'h00C3, miso_got);
    total++; if (miso_got[7:0] !== 8'h5A) begin bad++; $display("[TB] FAIL midrst_next_miso: got %h expected 5a", miso_got[7:0]); end
    total++; if (rx_log.size() !== n0 + 1) begin bad++; $display("[TB] FAIL midrst_next_pulses: got %0d expected %0d", rx_log.size(), n0 + 1); end
    total++; if (O_rx_data !== 8'hC3) begin bad++; $display("[TB] FAIL midrst_next_rx: got %h expected c3", O_rx_data); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
